mmio_hub: RTL and testbench

Parametrised memory-mapped peripheral hub for the Hack microcontroller. It sits beside `data_mem` on the CPU data bus (`addressM`/`outM`/`writeM`/`inM`) and provides:
- NOUT output registers and NIN input registers, with input synchronisation and change-event flags;
- a prescaled down-counting timer.

The uC top muxes `inM = hit ? rdata : data_mem output` and gates `data_mem` writes with `!hit`.

---
 rtl/uc_pkg.sv | 32 +++
 rtl/mmio_timer.sv | 91 +++++++++
 rtl/mmio_hub.sv | 158 +++++++++++++++
 tb/tb_mmio_hub.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared address-map constants and types for the Hack microcontroller
// memory-mapped peripherals.
package uc_pkg;

    localparam logic [14:0] DEF_OUT_BASE = 15'h7000;
    localparam logic [14:0] DEF_IN_BASE  = 15'h7400;
    localparam logic [14:0] DEF_TMR_BASE = 15'h7800;

    localparam int EVT_OFF  = 16;
    localparam int TMR_REGS = 5;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int STAT_EXP    = 0;

    typedef enum logic [2:0] {
        TMR_CTRL  = 3'd0,
        TMR_LOAD  = 3'd1,
        TMR_COUNT = 3'd2,
        TMR_STAT  = 3'd3,
        TMR_PRE   = 3'd4
    } tmr_reg_e;

    // Decoded write strobes from the hub to the timer.
    typedef struct packed {
        logic wr_ctrl;
        logic wr_load;
        logic wr_stat;
        logic wr_pre;
    } tmr_wr_t;

endpackage

// File: rtl/mmio_timer.sv
// Prescaled down-counting timer with one-shot or auto-reload expiry,
// driven by decoded write strobes from mmio_hub.
module mmio_timer
    import uc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk50m,
    input  logic          rst_n,
    input  logic [DW-1:0] wdata,
    input  tmr_wr_t       wr,
    output logic [DW-1:0] ctrl_q,
    output logic [DW-1:0] load_q,
    output logic [DW-1:0] count_q,
    output logic [DW-1:0] stat_q,
    output logic [DW-1:0] pre_q,
    output logic          tmr_exp
);

    logic          en;
    logic          reload;
    logic          exp_flag;
    logic [DW-1:0] load_r;
    logic [DW-1:0] pre_r;
    logic [DW-1:0] count;
    logic [DW-1:0] pc;
    logic          tick;
    logic          expire;

    // A LOAD write in the same cycle pre-empts both the decrement and expiry.
    assign tick   = en && (pc == pre_r);
    assign expire = tick && (count == '0) && !wr.wr_load;

    always_ff @(posedge clk50m) begin
        if (!rst_n) begin
            en       <= 1'b0;
            reload   <= 1'b0;
            exp_flag <= 1'b0;
            load_r   <= '0;
            pre_r    <= '0;
            count    <= '0;
            pc       <= '0;
            tmr_exp  <= 1'b0;
        end else begin
            if (wr.wr_ctrl) begin
                en     <= wdata[CTRL_EN];
                reload <= wdata[CTRL_RELOAD];
            end else if (expire && !reload) begin
                en <= 1'b0;
            end

            if (wr.wr_load) load_r <= wdata;
            if (wr.wr_pre)  pre_r  <= wdata;

            if (wr.wr_load) begin
                count <= wdata;
                pc    <= '0;
            end else if (en) begin
                if (tick) begin
                    pc <= '0;
                    if (count != '0)
                        count <= count - 1'b1;
                    else if (reload)
                        count <= load_r;
                end else begin
                    pc <= pc + 1'b1;
                end
            end

            if (expire)
                exp_flag <= 1'b1;
            else if (wr.wr_stat && wdata[STAT_EXP])
                exp_flag <= 1'b0;

            tmr_exp <= expire;
        end
    end

    always_comb begin
        ctrl_q              = '0;
        ctrl_q[CTRL_EN]     = en;
        ctrl_q[CTRL_RELOAD] = reload;
        stat_q              = '0;
        stat_q[STAT_EXP]    = exp_flag;
    end

    assign load_q  = load_r;
    assign count_q = count;
    assign pre_q   = pre_r;

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped peripheral hub: output registers, synchronised input
// registers with change events, and the prescaled timer.
module mmio_hub
    import uc_pkg::*;
#(
    parameter int            DW       = 16,
    parameter int            AW       = 15,
    parameter int            NOUT     = 3,
    parameter int            NIN      = 3,
    parameter int            SYNC     = 1,
    parameter logic [AW-1:0] OUT_BASE = DEF_OUT_BASE,
    parameter logic [AW-1:0] IN_BASE  = DEF_IN_BASE,
    parameter logic [AW-1:0] TMR_BASE = DEF_TMR_BASE
) (
    input  logic                      clk50m,
    input  logic                      rst_n,
    input  logic [AW-1:0]             addr,
    input  logic [DW-1:0]             wdata,
    input  logic                      we,
    output logic [DW-1:0]             rdata,
    output logic                      hit,
    output logic [NOUT-1:0][DW-1:0]   out_reg,
    input  logic [NIN-1:0][DW-1:0]    in_reg,
    output logic                      tmr_exp
);

    logic [AW-1:0]            out_off;
    logic [AW-1:0]            in_off;
    logic [AW-1:0]            tmr_off;
    logic                     out_hit;
    logic                     in_hit;
    logic                     evt_hit;
    logic                     tmr_hit;
    tmr_reg_e                 tmr_sel;
    tmr_wr_t                  tmr_wr;

    logic [NIN-1:0][DW-1:0]   synced;
    logic [NIN-1:0][DW-1:0]   prev;
    logic [NIN-1:0]           evt;
    logic [NIN-1:0]           evt_next;

    logic [DW-1:0]            ctrl_q;
    logic [DW-1:0]            load_q;
    logic [DW-1:0]            count_q;
    logic [DW-1:0]            stat_q;
    logic [DW-1:0]            pre_q;

    assign out_off = addr - OUT_BASE;
    assign in_off  = addr - IN_BASE;
    assign tmr_off = addr - TMR_BASE;

    assign out_hit = (addr >= OUT_BASE) && (out_off < AW'(NOUT));
    assign in_hit  = (addr >= IN_BASE)  && (in_off  < AW'(NIN));
    assign evt_hit = (addr == IN_BASE + AW'(EVT_OFF));
    assign tmr_hit = (addr >= TMR_BASE) && (tmr_off < AW'(TMR_REGS));
    assign tmr_sel = tmr_reg_e'(tmr_off[2:0]);
    assign hit     = out_hit || in_hit || evt_hit || tmr_hit;

    assign tmr_wr.wr_ctrl = we && tmr_hit && (tmr_sel == TMR_CTRL);
    assign tmr_wr.wr_load = we && tmr_hit && (tmr_sel == TMR_LOAD);
    assign tmr_wr.wr_stat = we && tmr_hit && (tmr_sel == TMR_STAT);
    assign tmr_wr.wr_pre  = we && tmr_hit && (tmr_sel == TMR_PRE);

    always_ff @(posedge clk50m) begin
        if (!rst_n) begin
            out_reg <= '0;
        end else begin
            for (int i = 0; i < NOUT; i++) begin
                if (we && out_hit && (out_off == AW'(i)))
                    out_reg[i] <= wdata;
            end
        end
    end

    generate
        if (SYNC != 0) begin : g_sync
            logic [NIN-1:0][DW-1:0] sync1;
            logic [NIN-1:0][DW-1:0] sync2;

            always_ff @(posedge clk50m) begin
                if (!rst_n) begin
                    sync1 <= '0;
                    sync2 <= '0;
                end else begin
                    sync1 <= in_reg;
                    sync2 <= sync1;
                end
            end

            assign synced = sync2;
        end else begin : g_direct
            assign synced = in_reg;
        end
    endgenerate

    // Hardware set is applied after the W1C so a coincident change survives.
    always_comb begin
        evt_next = evt;
        if (we && evt_hit)
            evt_next = evt & ~wdata[NIN-1:0];
        for (int i = 0; i < NIN; i++) begin
            if (synced[i] != prev[i])
                evt_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk50m) begin
        if (!rst_n) begin
            prev <= '0;
            evt  <= '0;
        end else begin
            prev <= synced;
            evt  <= evt_next;
        end
    end

    mmio_timer #(
        .DW(DW)
    ) u_timer (
        .clk50m  (clk50m),
        .rst_n   (rst_n),
        .wdata   (wdata),
        .wr      (tmr_wr),
        .ctrl_q  (ctrl_q),
        .load_q  (load_q),
        .count_q (count_q),
        .stat_q  (stat_q),
        .pre_q   (pre_q),
        .tmr_exp (tmr_exp)
    );

    always_comb begin
        rdata = '0;
        if (out_hit) begin
            for (int i = 0; i < NOUT; i++) begin
                if (out_off == AW'(i))
                    rdata = out_reg[i];
            end
        end else if (in_hit) begin
            for (int i = 0; i < NIN; i++) begin
                if (in_off == AW'(i))
                    rdata = synced[i];
            end
        end else if (evt_hit) begin
            rdata = DW'(evt);
        end else if (tmr_hit) begin
            case (tmr_sel)
                TMR_CTRL:  rdata = ctrl_q;
                TMR_LOAD:  rdata = load_q;
                TMR_COUNT: rdata = count_q;
                TMR_STAT:  rdata = stat_q;
                TMR_PRE:   rdata = pre_q;
                default:   rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub: directed scenarios plus randomized bus
// traffic compared against a behavioural model of the register map.
module tb_mmio_hub;

    logic              clk50m = 1'b0;
    logic              rst_n;
    logic [14:0]       addr;
    logic [15:0]       wdata;
    logic              we;
    logic [15:0]       rdata;
    logic              hit;
    logic [2:0][15:0]  out_reg;
    logic [2:0][15:0]  in_reg;
    logic              tmr_exp;

    int total = 0;
    int bad   = 0;

    logic        modelCheck = 1'b0;
    logic        got_hit;
    logic [15:0] got_rdata;
    logic        got_texp;

    // Behavioural model state
    logic [15:0] m_out [3];
    logic [47:0] m_hist [3];
    logic [2:0]  m_evt;
    logic        m_en, m_rel, m_exp, m_texp;
    logic [15:0] m_load, m_pre, m_count, m_pc;

    mmio_hub dut (
        .clk50m  (clk50m),
        .rst_n   (rst_n),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .rdata   (rdata),
        .hit     (hit),
        .out_reg (out_reg),
        .in_reg  (in_reg),
        .tmr_exp (tmr_exp)
    );

    always #5 clk50m = ~clk50m;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelRead(input logic [14:0] a, output logic h, output logic [15:0] r);
        int idx;
        h = 1'b0;
        r = 16'h0;
        if (a >= 15'h7000 && a < 15'h7003) begin
            idx = int'(a) - 'h7000;
            h = 1'b1;
            r = m_out[idx];
        end else if (a >= 15'h7400 && a < 15'h7403) begin
            idx = int'(a) - 'h7400;
            h = 1'b1;
            r = m_hist[1][idx*16 +: 16];
        end else if (a == 15'h7410) begin
            h = 1'b1;
            r = {13'h0, m_evt};
        end else if (a >= 15'h7800 && a < 15'h7805) begin
            h = 1'b1;
            case (int'(a) - 'h7800)
                0: r = {14'h0, m_rel, m_en};
                1: r = m_load;
                2: r = m_count;
                3: r = {15'h0, m_exp};
                default: r = m_pre;
            endcase
        end
    endtask

    task automatic modelEdge(input logic [14:0] a, input logic [15:0] d, input logic w,
                             input logic r, input logic [47:0] inv);
        logic [47:0] syn, prv;
        logic        wl, wc, ws, wp, tick, fire;
        logic [15:0] n_count, n_pc;
        if (!r) begin
            for (int k = 0; k < 3; k++) begin
                m_out[k]  = 16'h0;
                m_hist[k] = 48'h0;
            end
            m_evt = 3'b0;
            m_en = 1'b0; m_rel = 1'b0; m_exp = 1'b0; m_texp = 1'b0;
            m_load = 16'h0; m_pre = 16'h0; m_count = 16'h0; m_pc = 16'h0;
            return;
        end
        syn = m_hist[1];
        prv = m_hist[2];
        if (w && a == 15'h7410)
            m_evt = m_evt & ~d[2:0];
        for (int k = 0; k < 3; k++)
            if (syn[k*16 +: 16] != prv[k*16 +: 16])
                m_evt[k] = 1'b1;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = inv;
        if (w && a >= 15'h7000 && a < 15'h7003)
            m_out[int'(a) - 'h7000] = d;
        wc = w && (a == 15'h7800);
        wl = w && (a == 15'h7801);
        ws = w && (a == 15'h7803);
        wp = w && (a == 15'h7804);
        tick = m_en && (m_pc == m_pre);
        fire = tick && (m_count == 16'h0) && !wl;
        n_count = m_count;
        n_pc    = m_pc;
        if (wl) begin
            n_count = d;
            n_pc    = 16'h0;
        end else if (m_en) begin
            if (tick) begin
                n_pc = 16'h0;
                if (m_count != 16'h0) n_count = m_count - 16'h1;
                else if (m_rel)       n_count = m_load;
            end else begin
                n_pc = m_pc + 16'h1;
            end
        end
        if (fire)             m_exp = 1'b1;
        else if (ws && d[0])  m_exp = 1'b0;
        if (wc) begin
            m_en  = d[0];
            m_rel = d[1];
        end else if (fire && !m_rel) begin
            m_en = 1'b0;
        end
        if (wl) m_load = d;
        if (wp) m_pre  = d;
        m_count = n_count;
        m_pc    = n_pc;
        m_texp  = fire;
    endtask

    task automatic applyStimulus(input logic [14:0] a, input logic [15:0] d,
                                 input logic w, input logic r);
        logic        eh;
        logic [15:0] er;
        addr  = a;
        wdata = d;
        we    = w;
        rst_n = r;
        #2;
        got_hit   = hit;
        got_rdata = rdata;
        if (modelCheck) begin
            modelRead(a, eh, er);
            checkOutput("rnd_hit", got_hit, eh);
            checkOutput("rnd_rdata", got_rdata, er);
        end
        @(posedge clk50m);
        modelEdge(a, d, w, r, in_reg);
        #1;
        got_texp = tmr_exp;
        if (modelCheck) begin
            checkOutput("rnd_tmr_exp", got_texp, m_texp);
            for (int k = 0; k < 3; k++)
                checkOutput("rnd_out_reg", out_reg[k], m_out[k]);
        end
    endtask

    task automatic readCheck(input string tag, input logic [14:0] a,
                             input logic [15:0] exp, input logic exph);
        applyStimulus(a, 16'h0, 1'b0, 1'b1);
        checkOutput({tag, "_hit"}, got_hit, exph);
        checkOutput(tag, got_rdata, exp);
    endtask

    task automatic idle();
        applyStimulus(15'h0000, 16'h0, 1'b0, 1'b1);
    endtask

    initial begin
        int first_exp, pulses, lval, pval;
        logic [14:0] a;
        logic [15:0] d;
        logic        w, r;

        in_reg = '0;
        applyStimulus(15'h0, 16'h0, 1'b0, 1'b0);
        applyStimulus(15'h0, 16'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            checkOutput("reset_out_reg", out_reg[k], 16'h0);
        checkOutput("reset_tmr_exp", got_texp, 1'b0);
        readCheck("reset_count", 15'h7802, 16'h0, 1'b1);
        readCheck("reset_evt", 15'h7410, 16'h0, 1'b1);

        applyStimulus(15'h7001, 16'hBEEF, 1'b1, 1'b1);
        checkOutput("out_reg1", out_reg[1], 16'hBEEF);
        readCheck("rd_out1", 15'h7001, 16'hBEEF, 1'b1);
        readCheck("rd_unmapped", 15'h7003, 16'h0, 1'b0);

        in_reg[2] = 16'h00A5;
        readCheck("in2_edge0", 15'h7402, 16'h0000, 1'b1);
        readCheck("in2_edge1", 15'h7402, 16'h0000, 1'b1);
        readCheck("in2_edge2", 15'h7402, 16'h00A5, 1'b1);
        readCheck("evt_set", 15'h7410, 16'h0004, 1'b1);
        applyStimulus(15'h7410, 16'h0004, 1'b1, 1'b1);
        readCheck("evt_cleared", 15'h7410, 16'h0000, 1'b1);

        in_reg[0] = 16'h0001;
        idle();
        idle();
        applyStimulus(15'h7410, 16'h0001, 1'b1, 1'b1);
        readCheck("evt_set_wins", 15'h7410, 16'h0001, 1'b1);
        applyStimulus(15'h7410, 16'h0001, 1'b1, 1'b1);
        readCheck("evt_clr_again", 15'h7410, 16'h0000, 1'b1);

        lval = 3;
        pval = 1;
        applyStimulus(15'h7804, 16'(pval), 1'b1, 1'b1);
        applyStimulus(15'h7801, 16'(lval), 1'b1, 1'b1);
        applyStimulus(15'h7800, 16'h0001, 1'b1, 1'b1);
        first_exp = 0;
        pulses = 0;
        for (int e = 1; e <= 12; e++) begin
            idle();
            if (got_texp) begin
                pulses++;
                if (first_exp == 0) first_exp = e;
            end
        end
        checkOutput("oneshot_edge", first_exp, (lval + 1) * (pval + 1));
        checkOutput("oneshot_pulses", pulses, 1);
        readCheck("oneshot_ctrl", 15'h7800, 16'h0000, 1'b1);
        readCheck("oneshot_count", 15'h7802, 16'h0000, 1'b1);
        readCheck("oneshot_stat", 15'h7803, 16'h0001, 1'b1);
        applyStimulus(15'h7803, 16'h0001, 1'b1, 1'b1);
        readCheck("stat_w1c", 15'h7803, 16'h0000, 1'b1);

        applyStimulus(15'h7804, 16'h0000, 1'b1, 1'b1);
        applyStimulus(15'h7801, 16'h0002, 1'b1, 1'b1);
        applyStimulus(15'h7800, 16'h0003, 1'b1, 1'b1);
        for (int e = 0; e < 9; e++) begin
            if (e == 5 || e == 7)
                applyStimulus(15'h7803, 16'h0001, 1'b1, 1'b1);
            else if (e == 6)
                readCheck("exp_set_wins", 15'h7803, 16'h0001, 1'b1);
            else if (e == 8)
                readCheck("exp_w1c_plain", 15'h7803, 16'h0000, 1'b1);
            else
                readCheck("count_seq", 15'h7802, 16'(2 - (e % 3)), 1'b1);
            checkOutput("reload_pulse", got_texp, ((e + 1) % 3) == 0);
        end
        applyStimulus(15'h7800, 16'h0000, 1'b1, 1'b1);

        applyStimulus(15'h7801, 16'h0005, 1'b1, 1'b1);
        applyStimulus(15'h7800, 16'h0001, 1'b1, 1'b1);
        idle();
        idle();
        applyStimulus(15'h7000, 16'h1234, 1'b1, 1'b0);
        checkOutput("rst_tmr_exp", got_texp, 1'b0);
        for (int k = 0; k < 3; k++)
            checkOutput("rst_out_reg", out_reg[k], 16'h0);
        readCheck("rst_in0", 15'h7400, 16'h0, 1'b1);
        readCheck("rst_ctrl", 15'h7800, 16'h0, 1'b1);
        readCheck("rst_load", 15'h7801, 16'h0, 1'b1);
        readCheck("rst_count", 15'h7802, 16'h0, 1'b1);
        readCheck("rst_out0", 15'h7000, 16'h0, 1'b1);
        pulses = 0;
        for (int e = 0; e < 10; e++) begin
            idle();
            if (got_texp) pulses++;
        end
        checkOutput("rst_no_pulse", pulses, 0);

        modelCheck = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 16))
                0:  a = 15'h7000;
                1:  a = 15'h7001;
                2:  a = 15'h7002;
                3:  a = 15'h7003;
                4:  a = 15'h7400;
                5:  a = 15'h7401;
                6:  a = 15'h7402;
                7:  a = 15'h7403;
                8:  a = 15'h7410;
                9:  a = 15'h7800;
                10: a = 15'h7801;
                11: a = 15'h7802;
                12: a = 15'h7803;
                13: a = 15'h7804;
                14: a = 15'h7805;
                15: a = 15'h7800;
                default: a = 15'($urandom_range(0, 32767));
            endcase
            d = 16'($urandom);
            if (a == 15'h7801 || a == 15'h7804)
                d = d & 16'h0007;
            w = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 255) != 0);
            if ($urandom_range(0, 7) == 0)
                in_reg[$urandom_range(0, 2)] = 16'($urandom);
            applyStimulus(a, d, w, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
